// File: rtl/frame_config_sequencer.sv
// frame_config_sequencer
//   Takes a valid/ready stream of 32-bit config words and loads them into
//   tile frame latches. A header word selects the column, the first frame and
//   the frame count. Each data word after it is written into one frame: the
//   word is driven on FrameData, one FrameStrobe bit pulses, then the data is
//   held for another cycle.
// Ports
//   CLK, reset      clock; asynchronous active-high reset
//   in_data/valid   config word stream; in_ready is the accept handshake
//   FrameData       registered frame data to the config latches
//   FrameStrobe     one-hot latch enable, high only in the STROBE cycle
//   ColSelect       one-hot column gate, constant for a whole sequence
//   busy            high whenever the FSM is not IDLE
//   err_pulse       one-cycle pulse per rejected header
//   frames_done     saturating count of strobed frames
module frame_config_sequencer #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 32,
    parameter int NumColumns      = 4
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [FrameBitsPerRow-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [NumColumns-1:0]      ColSelect,
    output logic                       busy,
    output logic                       err_pulse,
    output logic [15:0]                frames_done
);

    typedef struct packed {
        logic [7:0] magic;
        logic [7:0] col;
        logic [7:0] start;
        logic [7:0] count;
    } hdr_t;

    typedef enum logic [2:0] {
        IDLE, WAIT_DATA, SETUP, STROBE, HOLD, DISCARD
    } state_t;

    localparam logic [7:0] MAGIC    = 8'hA5;
    localparam logic [8:0] NUM_COLS = 9'(NumColumns);
    localparam logic [8:0] MAX_FR   = 9'(MaxFramesPerCol);

    state_t                     state_q, state_d;
    logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
    logic [MaxFramesPerCol-1:0] frame_strobe_q, frame_strobe_d;
    logic [NumColumns-1:0]      col_sel_q, col_sel_d;
    logic                       err_q, err_d;
    logic [15:0]                frames_done_q, frames_done_d;
    logic [7:0]                 remaining_q, remaining_d;
    logic [7:0]                 idx_q, idx_d;

    hdr_t       hdr;
    logic       accept;
    logic [8:0] end_frame;
    logic       hdr_bad;

    always_comb begin
        hdr       = hdr_t'(in_data[31:0]);
        in_ready  = (state_q == IDLE) || (state_q == WAIT_DATA) || (state_q == DISCARD);
        accept    = in_valid && in_ready;
        // 9-bit sum so start+count cannot wrap past the frame range
        end_frame = {1'b0, hdr.start} + {1'b0, hdr.count};
        hdr_bad   = ({1'b0, hdr.col} >= NUM_COLS) || (hdr.count == 8'd0) ||
                    (end_frame > MAX_FR);

        state_d        = state_q;
        frame_data_d   = frame_data_q;
        frame_strobe_d = '0;
        col_sel_d      = col_sel_q;
        err_d          = 1'b0;
        frames_done_d  = frames_done_q;
        remaining_d    = remaining_q;
        idx_d          = idx_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hdr.magic != MAGIC) begin
                        err_d = 1'b1;
                    end else if (hdr_bad) begin
                        err_d = 1'b1;
                        // a nonzero count still has its data words in flight; swallow them
                        if (hdr.count != 8'd0) begin
                            remaining_d = hdr.count;
                            state_d     = DISCARD;
                        end
                    end else begin
                        col_sel_d   = NumColumns'(1) << hdr.col;
                        idx_d       = hdr.start;
                        remaining_d = hdr.count;
                        state_d     = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (accept) begin
                    frame_data_d = in_data;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                // strobe is registered, so it is launched from here and is
                // high exactly while state_q == STROBE
                frame_strobe_d = MaxFramesPerCol'(1) << idx_q;
                state_d        = STROBE;
            end
            STROBE: begin
                // counted on leaving STROBE so a reset mid-strobe leaves no partial count
                if (frames_done_q != 16'hFFFF) frames_done_d = frames_done_q + 16'd1;
                state_d = HOLD;
            end
            HOLD: begin
                idx_d       = idx_q + 8'd1;
                remaining_d = remaining_q - 8'd1;
                if (remaining_q == 8'd1) begin
                    col_sel_d = '0;
                    state_d   = IDLE;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            DISCARD: begin
                if (accept) begin
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            frame_data_q   <= '0;
            frame_strobe_q <= '0;
            col_sel_q      <= '0;
            err_q          <= 1'b0;
            frames_done_q  <= '0;
            remaining_q    <= '0;
            idx_q          <= '0;
        end else begin
            state_q        <= state_d;
            frame_data_q   <= frame_data_d;
            frame_strobe_q <= frame_strobe_d;
            col_sel_q      <= col_sel_d;
            err_q          <= err_d;
            frames_done_q  <= frames_done_d;
            remaining_q    <= remaining_d;
            idx_q          <= idx_d;
        end
    end

    assign FrameData   = frame_data_q;
    assign FrameStrobe = frame_strobe_q;
    assign ColSelect   = col_sel_q;
    assign busy        = (state_q != IDLE);
    assign err_pulse   = err_q;
    assign frames_done = frames_done_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench for frame_config_sequencer: header decode, frame strobe
// timing, error/discard paths, back-to-back throughput, async reset mid-strobe
// and counter saturation.
module tb_frame_config_sequencer;

    logic        CLK;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] FrameData;
    logic [31:0] FrameStrobe;
    logic [3:0]  ColSelect;
    logic        busy;
    logic        err_pulse;
    logic [15:0] frames_done;

    int errors = 0;
    int checks = 0;

    frame_config_sequencer #(
        .FrameBitsPerRow(32), .MaxFramesPerCol(32), .NumColumns(4)
    ) dut (
        .CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .ColSelect(ColSelect), .busy(busy), .err_pulse(err_pulse),
        .frames_done(frames_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a word from a negedge; returns at accept edge + 1ns with valid low.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        @(posedge CLK);
        #1 in_valid = 1'b0;
    endtask

    // One data word through SETUP/STROBE/HOLD; returns 1ns after HOLD exits.
    task automatic do_frame(input string tag, input logic [31:0] w, input logic [31:0] strobe);
        send(w);
        chk({tag, "_setup_data"},   FrameData, w);
        chk({tag, "_setup_strobe"}, FrameStrobe, 32'd0);
        chk({tag, "_setup_ready"},  {31'd0, in_ready}, 32'd0);
        @(posedge CLK); #1;
        chk({tag, "_strobe"},       FrameStrobe, strobe);
        chk({tag, "_strobe_data"},  FrameData, w);
        @(posedge CLK); #1;
        chk({tag, "_hold_strobe"},  FrameStrobe, 32'd0);
        chk({tag, "_hold_data"},    FrameData, w);
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [31:0] words [3];
        logic [31:0] exp_fd;
        logic [31:0] one;
        int ph;
        int fr;

        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_framedata", FrameData, 32'd0);
        chk("rst_strobe",    FrameStrobe, 32'd0);
        chk("rst_colsel",    {28'd0, ColSelect}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_err",       {31'd0, err_pulse}, 32'd0);
        chk("rst_done",      {16'd0, frames_done}, 32'd0);
        @(negedge CLK) reset = 1'b0;
        @(negedge CLK);
        chk("idle_ready",    {31'd0, in_ready}, 32'd1);

        // 1: two frames into column 1 starting at frame 3
        @(negedge CLK);
        send(32'hA5010302);
        chk("t1_colsel",  {28'd0, ColSelect}, 32'h2);
        chk("t1_busy",    {31'd0, busy}, 32'd1);
        do_frame("t1_f0", 32'hDEADBEEF, 32'h8);
        chk("t1_done1",   {16'd0, frames_done}, 32'd1);
        chk("t1_ready",   {31'd0, in_ready}, 32'd1);
        do_frame("t1_f1", 32'h12345678, 32'h10);
        chk("t1_done2",   {16'd0, frames_done}, 32'd2);
        chk("t1_idle",    {31'd0, busy}, 32'd0);
        chk("t1_colclr",  {28'd0, ColSelect}, 32'd0);
        chk("t1_keep",    FrameData, 32'h12345678);

        // 2: bad magic, then a good header
        @(negedge CLK);
        send(32'h5A000001);
        chk("t2_err",     {31'd0, err_pulse}, 32'd1);
        chk("t2_busy",    {31'd0, busy}, 32'd0);
        @(posedge CLK); #1;
        chk("t2_err_off", {31'd0, err_pulse}, 32'd0);
        chk("t2_strobe",  FrameStrobe, 32'd0);
        @(negedge CLK);
        send(32'hA5000001);
        chk("t2_err_hdr", {31'd0, err_pulse}, 32'd0);
        chk("t2_colsel",  {28'd0, ColSelect}, 32'h1);
        do_frame("t2_f0", 32'hCAFEF00D, 32'h1);
        chk("t2_done",    {16'd0, frames_done}, 32'd3);

        // 3: frame range overflow (31+2 > 32) -> discard two words
        @(negedge CLK);
        send(32'hA5001F02);
        chk("t3_err",     {31'd0, err_pulse}, 32'd1);
        chk("t3_busy",    {31'd0, busy}, 32'd1);
        chk("t3_colsel",  {28'd0, ColSelect}, 32'd0);
        send(32'h11111111);
        chk("t3_err_d0",  {31'd0, err_pulse}, 32'd0);
        chk("t3_fd0",     FrameData, 32'hCAFEF00D);
        chk("t3_strobe0", FrameStrobe, 32'd0);
        send(32'h22222222);
        chk("t3_fd1",     FrameData, 32'hCAFEF00D);
        chk("t3_strobe1", FrameStrobe, 32'd0);
        chk("t3_idle",    {31'd0, busy}, 32'd0);
        chk("t3_done",    {16'd0, frames_done}, 32'd3);

        // 4: back-to-back words with in_valid held high, column 2 frames 0..2
        @(negedge CLK);
        send(32'hA5020003);
        chk("t4_colsel",  {28'd0, ColSelect}, 32'h4);
        words[0] = 32'hA0A0A0A0; words[1] = 32'hB1B1B1B1; words[2] = 32'hC2C2C2C2;
        in_data  = words[0];
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            ph = k % 4;
            fr = k / 4;
            if (ph == 0) exp_fd = (k == 0) ? 32'hCAFEF00D : words[fr-1];
            else         exp_fd = words[fr];
            one = 32'd1 << fr;
            chk($sformatf("t4_ready_%0d", k),  {31'd0, in_ready}, (ph == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t4_data_%0d", k),   FrameData, exp_fd);
            chk($sformatf("t4_strobe_%0d", k), FrameStrobe, (ph == 2) ? one : 32'd0);
            chk($sformatf("t4_col_%0d", k),    {28'd0, ColSelect}, 32'h4);
            if (in_ready) begin
                @(posedge CLK);
                #1;
                if (fr < 2) in_data = words[fr+1];
                else        in_valid = 1'b0;
            end
        end
        @(negedge CLK);
        chk("t4_done",    {16'd0, frames_done}, 32'd6);
        chk("t4_idle",    {31'd0, busy}, 32'd0);

        // 5: reset in the middle of the first STROBE of a 4-frame sequence
        send(32'hA5030404);
        chk("t5_colsel",  {28'd0, ColSelect}, 32'h8);
        send(32'h5555AAAA);
        @(posedge CLK); #1;
        chk("t5_strobe",  FrameStrobe, 32'h10);
        reset = 1'b1;
        #1;
        chk("t5_rst_strobe", FrameStrobe, 32'd0);
        chk("t5_rst_data",   FrameData, 32'd0);
        chk("t5_rst_col",    {28'd0, ColSelect}, 32'd0);
        chk("t5_rst_busy",   {31'd0, busy}, 32'd0);
        chk("t5_rst_done",   {16'd0, frames_done}, 32'd0);
        chk("t5_rst_err",    {31'd0, err_pulse}, 32'd0);
        @(negedge CLK) reset = 1'b0;
        @(negedge CLK);
        send(32'hA5000001);
        do_frame("t5_f0", 32'hABCD0123, 32'h1);
        chk("t5_done",    {16'd0, frames_done}, 32'd1);

        // 6: counter saturation from FFFE
        @(negedge CLK);
        force dut.frames_done_q = 16'hFFFE;
        @(posedge CLK);
        @(negedge CLK);
        release dut.frames_done_q;
        @(negedge CLK);
        chk("t6_preload", {16'd0, frames_done}, 32'h0000FFFE);
        send(32'hA5010003);
        do_frame("t6_f0", 32'h00000001, 32'h1);
        chk("t6_sat1",    {16'd0, frames_done}, 32'h0000FFFF);
        do_frame("t6_f1", 32'h00000002, 32'h2);
        chk("t6_sat2",    {16'd0, frames_done}, 32'h0000FFFF);
        do_frame("t6_f2", 32'h00000003, 32'h4);
        chk("t6_sat3",    {16'd0, frames_done}, 32'h0000FFFF);
        chk("t6_idle",    {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
